// File: rtl/nf10_tx_rr_arbiter_if.sv
// rtl/nf10_tx_rr_arbiter_if.sv - bundle of flattened AXI-Stream lanes for the tx arbiter
// A lane count of 1 gives a plain stream; C_NUM_LANES > 1 packs lane i into slice i.
interface nf10_tx_rr_arbiter_if #(
  parameter int C_NUM_LANES        = 1,
  parameter int C_AXIS_DATA_WIDTH  = 64,
  parameter int C_AXIS_TUSER_WIDTH = 128
);
  logic [C_NUM_LANES*C_AXIS_DATA_WIDTH-1:0]   tdata;
  logic [C_NUM_LANES*C_AXIS_DATA_WIDTH/8-1:0] tstrb;
  logic [C_NUM_LANES*C_AXIS_TUSER_WIDTH-1:0]  tuser;
  logic [C_NUM_LANES-1:0]                     tvalid;
  logic [C_NUM_LANES-1:0]                     tready;
  logic [C_NUM_LANES-1:0]                     tlast;

  modport master (output tdata, tstrb, tuser, tvalid, tlast, input tready);
  modport slave  (input tdata, tstrb, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/nf10_tx_rr_arbiter.sv
// rtl/nf10_tx_rr_arbiter.sv - packet-locked round-robin arbiter onto one 10G tx stream
// Grants are held from arbitration until the tlast beat; data forwarding is combinational.
module nf10_tx_rr_arbiter #(
  parameter int C_NUM_INPUTS       = 4,
  parameter int C_AXIS_DATA_WIDTH  = 64,
  parameter int C_AXIS_TUSER_WIDTH = 128
) (
  input  logic                            axi_aclk,
  input  logic                            axi_reset,
  nf10_tx_rr_arbiter_if.slave             s_axis,
  nf10_tx_rr_arbiter_if.master            m_axis,
  output logic [$clog2(C_NUM_INPUTS)-1:0] grant_idx,
  output logic                            busy
);
  localparam int IW = $clog2(C_NUM_INPUTS);
  localparam int DW = C_AXIS_DATA_WIDTH;
  localparam int SW = C_AXIS_DATA_WIDTH / 8;
  localparam int UW = C_AXIS_TUSER_WIDTH;

  typedef enum logic {IDLE, SEND} state_t;

  state_t        state;
  logic [IW-1:0] grant;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] next_grant;
  logic [IW:0]   cand;
  logic          any_req;
  logic          fwd_valid;
  logic          fwd_last;

  // Scan rr_ptr, rr_ptr+1, ... with explicit wrap so non-power-of-2 counts work.
  always_comb begin
    any_req    = 1'b0;
    next_grant = rr_ptr;
    cand       = '0;
    for (int k = 0; k < C_NUM_INPUTS; k++) begin
      cand = {1'b0, rr_ptr} + (IW+1)'(k);
      if (cand >= (IW+1)'(C_NUM_INPUTS)) cand = cand - (IW+1)'(C_NUM_INPUTS);
      if (!any_req && s_axis.tvalid[cand[IW-1:0]]) begin
        any_req    = 1'b1;
        next_grant = cand[IW-1:0];
      end
    end
  end

  always_comb begin
    fwd_valid     = (state == SEND) && s_axis.tvalid[grant];
    fwd_last      = (state == SEND) && s_axis.tlast[grant];
    m_axis.tdata  = s_axis.tdata[int'(grant)*DW +: DW];
    m_axis.tstrb  = s_axis.tstrb[int'(grant)*SW +: SW];
    m_axis.tuser  = s_axis.tuser[int'(grant)*UW +: UW];
    m_axis.tvalid = fwd_valid;
    m_axis.tlast  = fwd_last;
    s_axis.tready = '0;
    if (state == SEND) s_axis.tready[grant] = m_axis.tready[0];
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      state  <= IDLE;
      grant  <= '0;
      rr_ptr <= '0;
      busy   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant <= next_grant;
            state <= SEND;
            busy  <= 1'b1;
          end
        end
        SEND: begin
          if (fwd_valid && m_axis.tready[0] && fwd_last) begin
            state  <= IDLE;
            busy   <= 1'b0;
            rr_ptr <= (grant == IW'(C_NUM_INPUTS-1)) ? '0 : grant + IW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign grant_idx = grant;
endmodule

// File: tb/tb_nf10_tx_rr_arbiter.sv
// tb/tb_nf10_tx_rr_arbiter.sv - directed and randomized bench for nf10_tx_rr_arbiter
// Randomized traffic is checked against a round-robin packet model kept in the bench.
module tb_nf10_tx_rr_arbiter;
  localparam int N  = 4;
  localparam int DW = 64;
  localparam int SW = DW / 8;
  localparam int UW = 128;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] grant_idx;
  logic       busy;
  int         total = 0;
  int         passed = 0;

  nf10_tx_rr_arbiter_if #(.C_NUM_LANES(N), .C_AXIS_DATA_WIDTH(DW), .C_AXIS_TUSER_WIDTH(UW)) s_axis ();
  nf10_tx_rr_arbiter_if #(.C_NUM_LANES(1), .C_AXIS_DATA_WIDTH(DW), .C_AXIS_TUSER_WIDTH(UW)) m_axis ();

  nf10_tx_rr_arbiter #(.C_NUM_INPUTS(N), .C_AXIS_DATA_WIDTH(DW), .C_AXIS_TUSER_WIDTH(UW)) dut (
    .axi_aclk  (clk),
    .axi_reset (rst),
    .s_axis    (s_axis),
    .m_axis    (m_axis),
    .grant_idx (grant_idx),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] beat_word(input int src, input int beat);
    return {8'(src), 48'h5a5a_0000_c3c3, 8'(beat)};
  endfunction

  task automatic set_in(input int i, input logic v, input logic l, input logic [DW-1:0] d);
    s_axis.tvalid[i]           = v;
    s_axis.tlast[i]            = l;
    s_axis.tdata[i*DW +: DW]   = d;
    s_axis.tstrb[i*SW +: SW]   = d[15:8];
    s_axis.tuser[i*UW +: UW]   = {~d, d};
  endtask

  task automatic clear_all();
    for (int i = 0; i < N; i++) set_in(i, 1'b0, 1'b0, '0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m_axis.tready = 1'b1;
    for (int i = 0; i < N; i++) set_in(i, 1'b1, 1'b1, beat_word(i, 0));
    for (int c = 0; c < 3; c++) begin
      step();
      total++; if (s_axis.tready !== 4'b0000) $display("FAIL reset_tready c%0d: got %b want 0000", c, s_axis.tready); else passed++;
      total++; if (m_axis.tvalid[0] !== 1'b0) $display("FAIL reset_tvalid c%0d: got %b want 0", c, m_axis.tvalid[0]); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL reset_busy c%0d: got %b want 0", c, busy); else passed++;
      total++; if (grant_idx !== 2'd0) $display("FAIL reset_grant c%0d: got %0d want 0", c, grant_idx); else passed++;
    end
    rst = 1'b0;
    clear_all();
  endtask

  task automatic test_single_input();
    logic [DW-1:0] w;
    m_axis.tready = 1'b1;
    set_in(2, 1'b1, 1'b0, beat_word(2, 0));
    settle();
    total++; if ({m_axis.tvalid[0], s_axis.tready} !== 5'b0) $display("FAIL single_idle: got tvalid=%b tready=%b want 0/0000", m_axis.tvalid[0], s_axis.tready); else passed++;
    step();
    total++; if ({busy, grant_idx} !== {1'b1, 2'd2}) $display("FAIL single_grant: got busy=%b grant=%0d want 1/2", busy, grant_idx); else passed++;
    for (int b = 0; b < 4; b++) begin
      w = beat_word(2, b);
      set_in(2, 1'b1, b == 3, w);
      settle();
      total++;
      if ({m_axis.tvalid[0], m_axis.tlast[0], m_axis.tdata, m_axis.tuser} !== {1'b1, b == 3, w, ~w, w})
        $display("FAIL single_beat%0d: got v=%b l=%b d=%h want v=1 l=%b d=%h", b, m_axis.tvalid[0], m_axis.tlast[0], m_axis.tdata, b == 3, w);
      else passed++;
      total++; if (s_axis.tready !== 4'b0100) $display("FAIL single_ready%0d: got %b want 0100", b, s_axis.tready); else passed++;
      step();
    end
    set_in(2, 1'b0, 1'b0, '0);
    settle();
    total++; if ({busy, grant_idx} !== {1'b0, 2'd2}) $display("FAIL single_end: got busy=%b grant=%0d want 0/2", busy, grant_idx); else passed++;
  endtask

  task automatic test_wrap_single_beat();
    set_in(0, 1'b1, 1'b1, beat_word(0, 0));
    set_in(3, 1'b1, 1'b1, beat_word(3, 0));
    step();
    settle();
    total++; if ({grant_idx, s_axis.tready} !== {2'd3, 4'b1000}) $display("FAIL wrap_first: got grant=%0d tready=%b want 3/1000", grant_idx, s_axis.tready); else passed++;
    total++; if ({m_axis.tvalid[0], m_axis.tlast[0], m_axis.tdata} !== {2'b11, beat_word(3, 0)}) $display("FAIL wrap_first_data: got %b%b %h", m_axis.tvalid[0], m_axis.tlast[0], m_axis.tdata); else passed++;
    step();
    set_in(3, 1'b0, 1'b0, '0);
    settle();
    total++; if (busy !== 1'b0) $display("FAIL wrap_one_cycle3: got busy=%b want 0", busy); else passed++;
    step();
    settle();
    total++; if ({grant_idx, s_axis.tready} !== {2'd0, 4'b0001}) $display("FAIL wrap_second: got grant=%0d tready=%b want 0/0001", grant_idx, s_axis.tready); else passed++;
    step();
    set_in(0, 1'b0, 1'b0, '0);
    settle();
    total++; if (busy !== 1'b0) $display("FAIL wrap_one_cycle0: got busy=%b want 0", busy); else passed++;
  endtask

  task automatic test_saturated();
    int cnt[N] = '{default: 0};
    int nbeats = 0;
    logic [N-1:0] rdy;
    logic [24:0] got, exp;
    clear_all();
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_axis.tready = 1'b1;
    for (int c = 0; c < 60 && nbeats < 18; c++) begin
      for (int i = 0; i < N; i++) set_in(i, 1'b1, cnt[i] == 2, beat_word(i, cnt[i]));
      settle();
      if (m_axis.tvalid[0] === 1'b1) begin
        exp = {8'((nbeats / 3) % N), 8'(nbeats % 3), nbeats % 3 == 2, 8'(1 + (nbeats / 3) * 4 + nbeats % 3)};
        got = {m_axis.tdata[63:56], m_axis.tdata[7:0], m_axis.tlast[0], 8'(c)};
        total++; if (got !== exp) $display("FAIL sat_beat%0d: got src/beat/last/cyc=%h want %h", nbeats, got, exp); else passed++;
        nbeats++;
      end
      rdy = s_axis.tready;
      step();
      for (int i = 0; i < N; i++) if (rdy[i]) cnt[i] = (cnt[i] + 1) % 3;
    end
    total++; if (nbeats !== 18) $display("FAIL sat_count: got %0d beats want 18", nbeats); else passed++;
  endtask

  task automatic test_stall();
    logic [7:0] sched_v = 8'b1100_1111;
    logic [7:0] sched_r = 8'b1111_0101;
    int b = 0;
    clear_all();
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_axis.tready = 1'b1;
    set_in(1, 1'b1, 1'b0, beat_word(1, 0));
    settle();
    step();
    set_in(0, 1'b1, 1'b1, beat_word(0, 0));
    for (int c = 0; c < 8; c++) begin
      m_axis.tready = sched_r[c];
      set_in(1, sched_v[c], b == 3, beat_word(1, b));
      settle();
      total++; if (s_axis.tready !== {2'b00, sched_r[c], 1'b0}) $display("FAIL stall_ready c%0d: got %b want %b", c, s_axis.tready, {2'b00, sched_r[c], 1'b0}); else passed++;
      total++; if (m_axis.tvalid[0] !== sched_v[c]) $display("FAIL stall_valid c%0d: got %b want %b", c, m_axis.tvalid[0], sched_v[c]); else passed++;
      if (m_axis.tvalid[0] && m_axis.tready[0] && s_axis.tready[1]) begin
        total++; if ({m_axis.tlast[0], m_axis.tdata} !== {b == 3, beat_word(1, b)}) $display("FAIL stall_data%0d: got %b %h", b, m_axis.tlast[0], m_axis.tdata); else passed++;
        b++;
      end
      step();
    end
    total++; if (b !== 4) $display("FAIL stall_beats: got %0d want 4", b); else passed++;
    set_in(1, 1'b0, 1'b0, '0);
    settle();
    total++; if (busy !== 1'b0) $display("FAIL stall_end: got busy=%b want 0", busy); else passed++;
    step();
    m_axis.tready = 1'b1;
    settle();
    total++; if ({busy, grant_idx, s_axis.tready} !== {1'b1, 2'd0, 4'b0001}) $display("FAIL stall_next: got busy=%b grant=%0d tready=%b want 1/0/0001", busy, grant_idx, s_axis.tready); else passed++;
    step();
    set_in(0, 1'b0, 1'b0, '0);
    settle();
  endtask

  task automatic test_reset_mid_packet();
    m_axis.tready = 1'b1;
    set_in(0, 1'b1, 1'b1, beat_word(0, 0));
    set_in(3, 1'b1, 1'b1, beat_word(3, 0));
    set_in(1, 1'b1, 1'b0, beat_word(1, 0));
    settle();
    step();
    total++; if (grant_idx !== 2'd1) $display("FAIL rstmid_grant: got %0d want 1", grant_idx); else passed++;
    for (int b = 0; b < 3; b++) begin
      set_in(1, 1'b1, 1'b0, beat_word(1, b));
      if (b == 2) rst = 1'b1;
      settle();
      step();
    end
    set_in(1, 1'b0, 1'b0, '0);
    settle();
    total++; if ({m_axis.tvalid[0], s_axis.tready, busy, grant_idx} !== 8'b0) $display("FAIL rstmid_outputs: got v=%b rdy=%b busy=%b grant=%0d want all 0", m_axis.tvalid[0], s_axis.tready, busy, grant_idx); else passed++;
    rst = 1'b0;
    step();
    settle();
    total++; if ({busy, grant_idx} !== {1'b1, 2'd0}) $display("FAIL rstmid_rearb: got busy=%b grant=%0d want 1/0", busy, grant_idx); else passed++;
    step();
    clear_all();
    settle();
  endtask

  task automatic test_random();
    logic [DW-1:0] d[N];
    logic [N-1:0]  tv, tl, exp_rdy;
    logic          rdy;
    int            mptr = 0;
    int            mgrant = 0;
    bit            mbusy = 1'b0;
    int            idx;
    clear_all();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        tv[i] = ($urandom_range(0, 2) != 0);
        tl[i] = ($urandom_range(0, 3) == 0);
        d[i]  = {$urandom, $urandom};
        set_in(i, tv[i], tl[i], d[i]);
      end
      rdy = ($urandom_range(0, 3) != 0);
      m_axis.tready = rdy;
      settle();
      if (!mbusy) begin
        total++; if ({busy, m_axis.tvalid[0], s_axis.tready} !== 6'b0) $display("FAIL rand_idle c%0d: got busy=%b v=%b rdy=%b want 0", c, busy, m_axis.tvalid[0], s_axis.tready); else passed++;
        total++; if (grant_idx !== 2'(mgrant)) $display("FAIL rand_idle_grant c%0d: got %0d want %0d", c, grant_idx, mgrant); else passed++;
        for (int k = 0; k < N; k++) begin
          idx = (mptr + k) % N;
          if (!mbusy && tv[idx]) begin
            mbusy  = 1'b1;
            mgrant = idx;
          end
        end
      end else begin
        exp_rdy = rdy ? (N'(1) << mgrant) : '0;
        total++; if ({busy, grant_idx} !== {1'b1, 2'(mgrant)}) $display("FAIL rand_send_grant c%0d: got busy=%b grant=%0d want 1/%0d", c, busy, grant_idx, mgrant); else passed++;
        total++; if (s_axis.tready !== exp_rdy) $display("FAIL rand_ready c%0d: got %b want %b", c, s_axis.tready, exp_rdy); else passed++;
        total++; if (m_axis.tvalid[0] !== tv[mgrant]) $display("FAIL rand_valid c%0d: got %b want %b", c, m_axis.tvalid[0], tv[mgrant]); else passed++;
        if (tv[mgrant]) begin
          total++;
          if ({m_axis.tdata, m_axis.tstrb, m_axis.tuser, m_axis.tlast[0]} !== {d[mgrant], d[mgrant][15:8], ~d[mgrant], d[mgrant], tl[mgrant]})
            $display("FAIL rand_data c%0d: got d=%h l=%b want d=%h l=%b", c, m_axis.tdata, m_axis.tlast[0], d[mgrant], tl[mgrant]);
          else passed++;
          if (rdy && tl[mgrant]) begin
            mbusy = 1'b0;
            mptr  = (mgrant + 1) % N;
          end
        end
      end
      step();
    end
  endtask

  initial begin
    m_axis.tready = 1'b0;
    clear_all();
    test_reset();
    test_single_input();
    test_wrap_single_beat();
    test_saturated();
    test_stall();
    test_reset_mid_packet();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
